game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 132 +++++++++++++
 tb/tb_game_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Top-level game flow controller: start, wave loading, play, pauses and game over.
// Tracks score, lives and wave number and drives the invader block's reset/enable.
module game_sequencer #(
   parameter int LIVES        = 3,
   parameter int LANDING_ROW  = 14,
   parameter int PAUSE_CYCLES = 25000000
) (
   input  logic        i_clk_25MHz,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_hit,
   input  logic        i_player_hit,
   input  logic [19:0] i_invaders_array,
   input  logic [3:0]  i_invaders_row,
   output logic        o_invaders_reset,
   output logic        o_play_enable,
   output logic [1:0]  o_speed_sel,
   output logic [9:0]  o_score,
   output logic [1:0]  o_lives,
   output logic        o_game_over,
   output logic [2:0]  o_state
);

   localparam int               CNT_W      = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
   localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
   localparam logic [9:0]       SCORE_MAX  = 10'd999;
   localparam logic [1:0]       WAVE_MAX   = 2'd3;
   localparam logic [3:0]       LAND_ROW   = 4'(LANDING_ROW);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      PLAY  = 3'd2,
      PAUSE = 3'd3,
      OVER  = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [9:0]       score, score_nxt;
   logic [1:0]       lives, lives_nxt;
   logic [1:0]       wave, wave_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             start_q, hit_q;
   logic             start_rise, hit_rise;
   logic             wave_clear, life_lost;

   // i_hit may stay high for several cycles per hit, so only its rising edge scores.
   assign start_rise = i_start & ~start_q;
   assign hit_rise   = i_hit & ~hit_q;
   assign wave_clear = (i_invaders_array == 20'd0);
   assign life_lost  = (i_invaders_row == LAND_ROW) | i_player_hit;

   always_comb begin
      state_nxt = state;
      score_nxt = score;
      lives_nxt = lives;
      wave_nxt  = wave;
      cnt_nxt   = cnt;
      case (state)
         IDLE, OVER: begin
            if (start_rise) begin
               state_nxt = LOAD;
               score_nxt = 10'd0;
               lives_nxt = LIVES_INIT;
               wave_nxt  = 2'd0;
            end
         end
         LOAD: state_nxt = PLAY;
         PLAY: begin
            if (hit_rise && (score != SCORE_MAX))
               score_nxt = score + 10'd1;
            // A cleared wave wins over a simultaneous landing or bomb strike.
            if (wave_clear) begin
               if (wave != WAVE_MAX)
                  wave_nxt = wave + 2'd1;
               state_nxt = PAUSE;
               cnt_nxt   = PAUSE_LOAD;
            end else if (life_lost) begin
               if (lives != 2'd0)
                  lives_nxt = lives - 2'd1;
               if (lives <= 2'd1) begin
                  state_nxt = OVER;
               end else begin
                  state_nxt = PAUSE;
                  cnt_nxt   = PAUSE_LOAD;
               end
            end
         end
         PAUSE: begin
            if (cnt == '0)
               state_nxt = LOAD;
            else
               cnt_nxt = cnt - 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk_25MHz) begin
      if (i_reset) begin
         state            <= IDLE;
         score            <= 10'd0;
         lives            <= LIVES_INIT;
         wave             <= 2'd0;
         cnt              <= '0;
         start_q          <= 1'b0;
         hit_q            <= 1'b0;
         o_invaders_reset <= 1'b1;
         o_play_enable    <= 1'b0;
         o_game_over      <= 1'b0;
      end else begin
         state            <= state_nxt;
         score            <= score_nxt;
         lives            <= lives_nxt;
         wave             <= wave_nxt;
         cnt              <= cnt_nxt;
         start_q          <= i_start;
         hit_q            <= i_hit;
         // Flags are registered from the next state so they line up with o_state.
         o_invaders_reset <= (state_nxt == IDLE) || (state_nxt == LOAD);
         o_play_enable    <= (state_nxt == PLAY);
         o_game_over      <= (state_nxt == OVER);
      end
   end

   assign o_state     = state;
   assign o_score     = score;
   assign o_lives     = lives;
   assign o_speed_sel = wave;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus randomized play checked
// against a cycle-level behavioural model of the game rules.
`timescale 1ns/1ps
module tb_game_sequencer;

   localparam int LIVES = 3;
   localparam int LROW  = 14;
   localparam int PC    = 4;
   localparam logic [19:0] FULL = 20'hFFFFF;

   logic        clk = 1'b0;
   logic        rst, start, hit, phit;
   logic [19:0] arr;
   logic [3:0]  row;
   logic        o_invaders_reset, o_play_enable, o_game_over;
   logic [1:0]  o_speed_sel, o_lives;
   logic [9:0]  o_score;
   logic [2:0]  o_state;

   always #20 clk = ~clk;

   game_sequencer #(.LIVES(LIVES), .LANDING_ROW(LROW), .PAUSE_CYCLES(PC)) dut (
      .i_clk_25MHz     (clk),
      .i_reset         (rst),
      .i_start         (start),
      .i_hit           (hit),
      .i_player_hit    (phit),
      .i_invaders_array(arr),
      .i_invaders_row  (row),
      .o_invaders_reset(o_invaders_reset),
      .o_play_enable   (o_play_enable),
      .o_speed_sel     (o_speed_sel),
      .o_score         (o_score),
      .o_lives         (o_lives),
      .o_game_over     (o_game_over),
      .o_state         (o_state)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model: game mode 0..4, plus the number of pause cycles still to spend.
   int m_state = 0, m_score = 0, m_lives = LIVES, m_wave = 0, m_left = 0;
   bit m_sq = 0, m_hq = 0;

   task automatic new_game();
      m_state = 1; m_score = 0; m_lives = LIVES; m_wave = 0;
   endtask

   task automatic model_step();
      bit sr, hr;
      sr = start && !m_sq;
      hr = hit && !m_hq;
      if (rst) begin
         m_state = 0; m_score = 0; m_lives = LIVES; m_wave = 0; m_left = 0;
         m_sq = 0; m_hq = 0;
      end else begin
         m_sq = start;
         m_hq = hit;
         if (m_state == 0 || m_state == 4) begin
            if (sr) new_game();
         end else if (m_state == 1) begin
            m_state = 2;
         end else if (m_state == 2) begin
            if (hr) m_score = (m_score >= 999) ? 999 : m_score + 1;
            if (arr == 0) begin
               m_wave  = (m_wave >= 3) ? 3 : m_wave + 1;
               m_state = 3;
               m_left  = PC;
            end else if (row == LROW || phit) begin
               m_lives = m_lives - 1;
               if (m_lives == 0) m_state = 4;
               else begin m_state = 3; m_left = PC; end
            end
         end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_state = 1;
         end
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; step(); step(); rst = 0;
      n_checks++;
      if (o_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", o_state); else n_pass++;
      n_checks++;
      if ({o_invaders_reset, o_play_enable, o_game_over} !== 3'b100)
         $display("FAIL reset_flags: got %b want 100", {o_invaders_reset, o_play_enable, o_game_over});
      else n_pass++;
      n_checks++;
      if ({o_score, o_lives, o_speed_sel} !== {10'd0, 2'd3, 2'd0})
         $display("FAIL reset_counts: got score %0d lives %0d speed %0d want 0 3 0", o_score, o_lives, o_speed_sel);
      else n_pass++;
   endtask

   task automatic test_start();
      start = 1; step();
      n_checks++;
      if ({o_state, o_invaders_reset, o_play_enable} !== {3'd1, 1'b1, 1'b0})
         $display("FAIL start_load: got state %0d inv_rst %b play %b want 1 1 0", o_state, o_invaders_reset, o_play_enable);
      else n_pass++;
      start = 0; step();
      n_checks++;
      if ({o_state, o_invaders_reset, o_play_enable} !== {3'd2, 1'b0, 1'b1})
         $display("FAIL start_play: got state %0d inv_rst %b play %b want 2 0 1", o_state, o_invaders_reset, o_play_enable);
      else n_pass++;
      n_checks++;
      if ({o_lives, o_score} !== {2'd3, 10'd0})
         $display("FAIL start_counts: got lives %0d score %0d want 3 0", o_lives, o_score);
      else n_pass++;
   endtask

   task automatic test_hits();
      repeat (2) begin
         hit = 1; step(); step(); hit = 0; step();
      end
      n_checks++;
      if (o_score !== 10'd2) $display("FAIL hit_two: got %0d want 2", o_score); else n_pass++;
      for (int i = 0; i < 997; i++) begin
         hit = 1; step(); hit = 0; step();
      end
      n_checks++;
      if (o_score !== 10'd999) $display("FAIL hit_reach_999: got %0d want 999", o_score); else n_pass++;
      hit = 1; step(); hit = 0; step();
      n_checks++;
      if ({o_score, o_state} !== {10'd999, 3'd2})
         $display("FAIL hit_saturate: got score %0d state %0d want 999 2", o_score, o_state);
      else n_pass++;
   endtask

   task automatic test_wave_clear();
      arr = 20'd0; step(); arr = FULL;
      for (int i = 0; i < PC; i++) begin
         n_checks++;
         if ({o_state, o_play_enable, o_invaders_reset} !== {3'd3, 2'b00})
            $display("FAIL clear_pause_%0d: got state %0d play %b inv_rst %b want 3 0 0", i, o_state, o_play_enable, o_invaders_reset);
         else n_pass++;
         step();
      end
      n_checks++;
      if (o_state !== 3'd1) $display("FAIL clear_load: got %0d want 1", o_state); else n_pass++;
      step();
      n_checks++;
      if ({o_state, o_speed_sel} !== {3'd2, 2'd1})
         $display("FAIL clear_speed1: got state %0d speed %0d want 2 1", o_state, o_speed_sel);
      else n_pass++;
      repeat (3) begin
         arr = 20'd0; step(); arr = FULL; repeat (5) step();
      end
      n_checks++;
      if ({o_state, o_speed_sel, o_score} !== {3'd2, 2'd3, 10'd999})
         $display("FAIL clear_speed_sat: got state %0d speed %0d score %0d want 2 3 999", o_state, o_speed_sel, o_score);
      else n_pass++;
   endtask

   task automatic test_landing();
      rst = 1; step(); rst = 0;
      start = 1; step(); start = 0; step();
      row = 4'd14; step(); row = 4'd0;
      n_checks++;
      if ({o_state, o_lives} !== {3'd3, 2'd2})
         $display("FAIL land_first: got state %0d lives %0d want 3 2", o_state, o_lives);
      else n_pass++;
      repeat (5) step();
      row = 4'd14; step(); row = 4'd0;
      n_checks++;
      if ({o_state, o_lives} !== {3'd3, 2'd1})
         $display("FAIL land_second: got state %0d lives %0d want 3 1", o_state, o_lives);
      else n_pass++;
      start = 1;
      repeat (5) step();
      n_checks++;
      if (o_state !== 3'd2) $display("FAIL land_back_to_play: got %0d want 2", o_state); else n_pass++;
      row = 4'd14; step(); row = 4'd0;
      n_checks++;
      if ({o_state, o_lives, o_game_over, o_play_enable} !== {3'd4, 2'd0, 2'b10})
         $display("FAIL land_over: got state %0d lives %0d over %b play %b want 4 0 1 0", o_state, o_lives, o_game_over, o_play_enable);
      else n_pass++;
      repeat (3) step();
      hit = 1; step(); hit = 0; step();
      n_checks++;
      if ({o_state, o_score, o_lives} !== {3'd4, 10'd0, 2'd0})
         $display("FAIL held_start_no_restart: got state %0d score %0d lives %0d want 4 0 0", o_state, o_score, o_lives);
      else n_pass++;
      start = 0; step();
      start = 1; step();
      n_checks++;
      if ({o_state, o_lives, o_score, o_game_over} !== {3'd1, 2'd3, 10'd0, 1'b0})
         $display("FAIL restart_load: got state %0d lives %0d score %0d over %b want 1 3 0 0", o_state, o_lives, o_score, o_game_over);
      else n_pass++;
      start = 0; step();
   endtask

   task automatic test_simultaneous();
      arr = 20'd0; phit = 1; hit = 1; step();
      arr = FULL; phit = 0; hit = 0;
      n_checks++;
      if ({o_state, o_lives, o_score, o_speed_sel} !== {3'd3, 2'd3, 10'd1, 2'd1})
         $display("FAIL simultaneous: got state %0d lives %0d score %0d speed %0d want 3 3 1 1", o_state, o_lives, o_score, o_speed_sel);
      else n_pass++;
   endtask

   task automatic test_reset_mid_pause();
      step();
      rst = 1; step(); rst = 0;
      n_checks++;
      if ({o_state, o_score, o_lives, o_speed_sel} !== {3'd0, 10'd0, 2'd3, 2'd0})
         $display("FAIL reset_mid_pause: got state %0d score %0d lives %0d speed %0d want 0 0 3 0", o_state, o_score, o_lives, o_speed_sel);
      else n_pass++;
      n_checks++;
      if ({o_invaders_reset, o_play_enable, o_game_over} !== 3'b100)
         $display("FAIL reset_mid_pause_flags: got %b want 100", {o_invaders_reset, o_play_enable, o_game_over});
      else n_pass++;
   endtask

   task automatic test_random();
      logic [19:0] got, exp;
      for (int i = 0; i < 4000; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         start = ($urandom_range(0, 3) == 0);
         hit   = $urandom_range(0, 1) == 1;
         phit  = ($urandom_range(0, 24) == 0);
         arr   = ($urandom_range(0, 19) == 0) ? 20'd0 : (20'($urandom) | 20'd1);
         row   = ($urandom_range(0, 24) == 0) ? 4'd14 : 4'($urandom_range(0, 13));
         step();
         got = {o_state, o_play_enable, o_invaders_reset, o_game_over, o_score, o_lives, o_speed_sel};
         exp = {3'(m_state), (m_state == 2), (m_state <= 1), (m_state == 4),
                10'(m_score), 2'(m_lives), 2'(m_wave)};
         n_checks++;
         if (got !== exp) $display("FAIL random_cycle_%0d: got %h want %h", i, got, exp);
         else n_pass++;
      end
      rst = 0; start = 0; hit = 0; phit = 0; arr = FULL; row = 4'd0;
   endtask

   initial begin
      rst = 1; start = 0; hit = 0; phit = 0; arr = FULL; row = 4'd0;
      test_reset();
      test_start();
      test_hits();
      test_wave_clear();
      test_landing();
      test_simultaneous();
      test_reset_mid_pause();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
